// File: rtl/mem_access_controller.sv
// Data-memory access controller for the MEM stage: classifies the access,
// checks alignment, drives a request/ready bus handshake, waits for read data,
// extends loads, and guards every access with an 8-bit watchdog.
//
// state | meaning
// IDLE  | no access in flight; accepts a new aligned access
// REQ   | request on the bus, held stable until dmem_ready
// WAIT  | load accepted by the bus, waiting for dmem_rvalid
module mem_access_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic        wb_load,
  input  logic [1:0]  mem_store_type,
  input  logic [2:0]  mem_load_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        pipe_stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [1:0] ST_SB = 2'b00, ST_SH = 2'b01, ST_SW = 2'b10, ST_DEF = 2'b11;
  localparam logic [2:0] LD_LB = 3'b000, LD_LH = 3'b001, LD_LW = 3'b010,
                         LD_LBU = 3'b011, LD_LHU = 3'b100, LD_DEF = 3'b111;
  localparam logic [7:0] WDOG_LAST = 8'd254;

  state_t      state;
  logic [7:0]  wdog;
  logic        drop;
  logic [2:0]  lat_ltype;
  logic [1:0]  lat_off;
  logic        lat_store;

  logic        is_store, is_load, misaligned, accept;
  logic [3:0]  wstrb_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  // Access classification, alignment check and store lane placement.
  always_comb begin
    is_store   = mem_write && (mem_store_type != ST_DEF);
    is_load    = !is_store && wb_load && (mem_load_type != LD_DEF);
    misaligned = 1'b0;
    wstrb_nxt  = 4'b0000;
    wdata_nxt  = 32'h0;
    if (is_store) begin
      case (mem_store_type)
        ST_SB: begin
          wstrb_nxt = 4'b0001 << mem_addr[1:0];
          wdata_nxt = {4{mem_wdata[7:0]}};
        end
        ST_SH: begin
          misaligned = mem_addr[0];
          wstrb_nxt  = 4'b0011 << mem_addr[1:0];
          wdata_nxt  = {2{mem_wdata[15:0]}};
        end
        ST_SW: begin
          misaligned = (mem_addr[1:0] != 2'b00);
          wstrb_nxt  = 4'b1111;
          wdata_nxt  = mem_wdata;
        end
        default: ;
      endcase
    end else if (is_load) begin
      case (mem_load_type)
        LD_LH, LD_LHU: misaligned = mem_addr[0];
        LD_LW:         misaligned = (mem_addr[1:0] != 2'b00);
        default:       misaligned = 1'b0;
      endcase
    end
    // rst_n gates acceptance so nothing (including the stall) leaks out during reset.
    accept = rst_n && (state == IDLE) && mem_valid && !flush &&
             (is_store || is_load) && !misaligned;
  end

  // Stall, load result selection and extension.
  always_comb begin
    pipe_stall = accept ||
                 ((state == REQ) && !dmem_ready) ||
                 ((state == WAIT) && !dmem_rvalid);
    load_valid = (state == WAIT) && dmem_rvalid && !drop && !flush;
    rd_shift   = dmem_rdata >> {lat_off, 3'b000};
    case (lat_ltype)
      LD_LB:   load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      LD_LH:   load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      LD_LW:   load_ext = dmem_rdata;
      LD_LBU:  load_ext = {24'h0, rd_shift[7:0]};
      LD_LHU:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = 32'h0;
    endcase
    load_data = load_valid ? load_ext : 32'h0;
  end

  // Access FSM with registered bus outputs, watchdog and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wdog         <= 8'h0;
      drop         <= 1'b0;
      lat_ltype    <= 3'b0;
      lat_off      <= 2'b0;
      lat_store    <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_wstrb   <= 4'h0;
      dmem_wdata   <= 32'h0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (accept) begin
            state      <= REQ;
            wdog       <= 8'h0;
            lat_store  <= is_store;
            lat_ltype  <= mem_load_type;
            lat_off    <= mem_addr[1:0];
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {mem_addr[31:2], 2'b00};
            dmem_wstrb <= wstrb_nxt;
            dmem_wdata <= wdata_nxt;
          end else if (mem_valid && !flush && (is_store || is_load) && misaligned) begin
            misalign_err <= 1'b1;
          end
        end
        REQ: begin
          // A handshake completing in the same cycle as a flush is honoured.
          if (dmem_ready || flush || (wdog == WDOG_LAST)) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'h0;
            dmem_wdata <= 32'h0;
            dmem_addr  <= 32'h0;
          end
          if (dmem_ready) begin
            if (lat_store) begin
              state <= IDLE;
            end else begin
              state <= WAIT;
              wdog  <= 8'h0;
              drop  <= 1'b0;
            end
          end else if (flush) begin
            state <= IDLE;
          end else if (wdog == WDOG_LAST) begin
            state   <= IDLE;
            bus_err <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else if (wdog == WDOG_LAST) begin
            state   <= IDLE;
            bus_err <= 1'b1;
            drop    <= 1'b0;
          end else begin
            wdog <= wdog + 8'd1;
            if (flush) drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
module tb_mem_access_controller;

  logic        clk;
  logic        rst_n;
  logic        mem_valid, mem_write, wb_load;
  logic [1:0]  mem_store_type;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_addr, mem_wdata;
  logic        flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        pipe_stall, load_valid;
  logic [31:0] load_data;
  logic        misalign_err, bus_err;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] load_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  mem_access_controller dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_write(mem_write), .wb_load(wb_load),
    .mem_store_type(mem_store_type), .mem_load_type(mem_load_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .pipe_stall(pipe_stall), .load_valid(load_valid), .load_data(load_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  // Reference load extension, byte-indexed.
  function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = (off == 2'd0) ? w[7:0] : (off == 2'd1) ? w[15:8] : (off == 2'd2) ? w[23:16] : w[31:24];
    h = off[1] ? w[31:16] : w[15:0];
    case (lt)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b011:  return {24'h0, b};
      3'b100:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bus_t model_bus(input bit st, input logic [1:0] stype,
                                     input logic [31:0] addr, input logic [31:0] wd);
    bus_t e;
    e.we   = st;
    e.addr = {addr[31:2], 2'b00};
    e.strb = 4'b0000;
    e.data = 32'h0;
    if (st) begin
      case (stype)
        2'b00: begin
          e.strb = (addr[1:0] == 2'd0) ? 4'b0001 : (addr[1:0] == 2'd1) ? 4'b0010 :
                   (addr[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
          e.data = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end
        2'b01: begin
          e.strb = addr[1] ? 4'b1100 : 4'b0011;
          e.data = {wd[15:0], wd[15:0]};
        end
        default: begin
          e.strb = 4'b1111;
          e.data = wd;
        end
      endcase
    end
    return e;
  endfunction

  task automatic idle_inputs();
    mem_valid = 0; mem_write = 0; wb_load = 0;
    mem_store_type = 2'b11; mem_load_type = 3'b111;
    mem_addr = 0; mem_wdata = 0; flush = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // Caller must be at posedge+1 with the FSM idle; returns at posedge+1.
  task automatic do_access(input bit st, input logic [1:0] stype, input logic [2:0] ltype,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                           output int stalls);
    bus_t eb;
    logic [31:0] el;
    int n;
    bit done;
    mem_valid = 1; mem_write = st; wb_load = !st;
    mem_store_type = st ? stype : 2'b11;
    mem_load_type  = st ? 3'b111 : ltype;
    mem_addr = addr; mem_wdata = wd;
    bus_q.push_back(model_bus(st, stype, addr, wd));
    if (!st) load_q.push_back(model_load(ltype, addr[1:0], rdata));
    stalls = 0;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b0) begin
      n_errors++; $display("FAIL accept_req_low: dmem_req=%b required 0", dmem_req);
    end
    if (pipe_stall) stalls++;
    @(posedge clk); #1;
    mem_valid = 0; mem_write = 0; wb_load = 0;
    n = 0; done = 0;
    while (!done) begin
      dmem_ready = (n >= rdy_dly);
      @(negedge clk);
      if (n == 0) begin
        n_checks++;
        if (bus_q.size() == 0) begin
          n_errors++; $display("FAIL bus_scoreboard_empty: no expected request queued");
        end else begin
          eb = bus_q.pop_front();
          if (dmem_we !== eb.we || dmem_addr !== eb.addr || dmem_wstrb !== eb.strb ||
              (eb.we && dmem_wdata !== eb.data)) begin
            n_errors++;
            $display("FAIL bus_fields: we=%b addr=%h strb=%b wdata=%h required we=%b addr=%h strb=%b wdata=%h",
                     dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, eb.we, eb.addr, eb.strb, eb.data);
          end
        end
      end
      n_checks++;
      if (dmem_req !== 1'b1) begin
        n_errors++; $display("FAIL req_held: dmem_req=%b required 1 (cycle %0d)", dmem_req, n);
      end
      if (pipe_stall) stalls++;
      done = dmem_ready;
      @(posedge clk); #1;
      dmem_ready = 0;
      n++;
      if (n > 300 && !done) begin
        n_errors++; $display("FAIL req_timeout: handshake not done after %0d cycles", n);
        done = 1;
      end
    end
    if (!st) begin
      n = 0; done = 0;
      while (!done) begin
        dmem_rvalid = (n >= rv_dly);
        dmem_rdata  = dmem_rvalid ? rdata : 32'hDEAD_BEEF;
        @(negedge clk);
        if (dmem_rvalid) begin
          el = (load_q.size() != 0) ? load_q.pop_front() : 32'hXXXX_XXXX;
          n_checks++;
          if (load_valid !== 1'b1 || load_data !== el) begin
            n_errors++;
            $display("FAIL load_result: valid=%b data=%h required valid=1 data=%h",
                     load_valid, load_data, el);
          end
          done = 1;
        end else begin
          n_checks++;
          if (load_valid !== 1'b0 || dmem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_outputs: load_valid=%b dmem_req=%b required 0 0", load_valid, dmem_req);
          end
        end
        if (pipe_stall) stalls++;
        @(posedge clk); #1;
        dmem_rvalid = 0;
        n++;
        if (n > 300 && !done) begin
          n_errors++; $display("FAIL wait_timeout: no completion after %0d cycles", n);
          done = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    mem_valid = 1; mem_write = 1; mem_store_type = 2'b10; mem_addr = 32'h100; mem_wdata = 32'h55;
    dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if ({dmem_req, dmem_we, dmem_wstrb, pipe_stall, load_valid, misalign_err, bus_err} !== 10'b0 ||
        dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || load_data !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: req=%b we=%b strb=%b stall=%b lv=%b ld=%h addr=%h wd=%h required all 0",
               dmem_req, dmem_we, dmem_wstrb, pipe_stall, load_valid, load_data, dmem_addr, dmem_wdata);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    int s;
    do_access(1, 2'b00, 3'b111, 32'h0000_1003, 32'h0000_00AB, 0, 2, 0, s);
    n_checks++;
    if (s !== 3) begin n_errors++; $display("FAIL sb_stall_cycles: %0d required 3", s); end
    do_access(1, 2'b01, 3'b111, 32'h0000_1022, 32'hFFFF_BEEF, 0, 0, 0, s);
    n_checks++;
    if (s !== 1) begin n_errors++; $display("FAIL sh_stall_cycles: %0d required 1", s); end
    do_access(1, 2'b10, 3'b111, 32'h0000_1040, 32'hCAFE_F00D, 0, 1, 0, s);
    n_checks++;
    if (s !== 2) begin n_errors++; $display("FAIL sw_stall_cycles: %0d required 2", s); end
  endtask

  task automatic test_load();
    int s;
    do_access(0, 2'b11, 3'b000, 32'h0000_2001, 0, 32'h0000_8000, 0, 0, s);
    @(negedge clk);
    n_checks++;
    if (load_valid !== 1'b0 || load_data !== 32'h0) begin
      n_errors++; $display("FAIL load_valid_pulse: valid=%b data=%h required 0 0", load_valid, load_data);
    end
    @(posedge clk); #1;
    do_access(0, 2'b11, 3'b011, 32'h0000_2001, 0, 32'h0000_8000, 1, 2, s);
    n_checks++;
    if (s !== 4) begin n_errors++; $display("FAIL lbu_stall_cycles: %0d required 4", s); end
    do_access(0, 2'b11, 3'b001, 32'h0000_2002, 0, 32'h8001_1234, 0, 1, s);
    do_access(0, 2'b11, 3'b100, 32'h0000_2002, 0, 32'h8001_1234, 0, 0, s);
    do_access(0, 2'b11, 3'b010, 32'h0000_3000, 0, 32'hA5A5_0F0F, 0, 0, s);
    do_access(0, 2'b11, 3'b000, 32'h0000_2003, 0, 32'h7F00_0000, 0, 0, s);
  endtask

  task automatic test_misalign(input bit st, input logic [1:0] stype, input logic [2:0] ltype,
                               input logic [31:0] addr, input string nm);
    mem_valid = 1; mem_write = st; wb_load = !st;
    mem_store_type = st ? stype : 2'b11;
    mem_load_type  = st ? 3'b111 : ltype;
    mem_addr = addr;
    @(negedge clk);
    n_checks++;
    if (pipe_stall !== 1'b0 || dmem_req !== 1'b0) begin
      n_errors++; $display("FAIL %s_no_stall: stall=%b req=%b required 0 0", nm, pipe_stall, dmem_req);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (misalign_err !== 1'b1 || dmem_req !== 1'b0) begin
      n_errors++; $display("FAIL %s_err: misalign_err=%b req=%b required 1 0", nm, misalign_err, dmem_req);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (misalign_err !== 1'b0 || dmem_req !== 1'b0) begin
      n_errors++; $display("FAIL %s_err_pulse: misalign_err=%b req=%b required 0 0", nm, misalign_err, dmem_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_watchdog();
    int cnt;
    bit seen;
    mem_valid = 1; wb_load = 1; mem_load_type = 3'b010; mem_addr = 32'h0000_4000;
    @(posedge clk); #1;
    idle_inputs();
    dmem_ready = 1;
    @(posedge clk); #1;
    dmem_ready = 0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus_err) seen = 1;
      else if (pipe_stall) cnt++;
      if (!seen) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (!seen || cnt !== 255) begin
      n_errors++; $display("FAIL watchdog_timeout: bus_err_seen=%b wait_cycles=%0d required 1 255", seen, cnt);
    end
    n_checks++;
    if (pipe_stall !== 1'b0 || dmem_req !== 1'b0 || load_valid !== 1'b0) begin
      n_errors++; $display("FAIL watchdog_idle: stall=%b req=%b lv=%b required 0 0 0", pipe_stall, dmem_req, load_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus_err !== 1'b0) begin n_errors++; $display("FAIL bus_err_pulse: %b required 0", bus_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_wait();
    int s;
    mem_valid = 1; wb_load = 1; mem_load_type = 3'b010; mem_addr = 32'h0000_5000;
    @(posedge clk); #1;
    idle_inputs();
    dmem_ready = 1;
    @(posedge clk); #1;
    dmem_ready = 0;
    flush = 1;
    @(negedge clk);
    n_checks++;
    if (pipe_stall !== 1'b1 || load_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush_wait_stall: stall=%b lv=%b required 1 0", pipe_stall, load_valid);
    end
    @(posedge clk); #1;
    flush = 0; dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (load_valid !== 1'b0 || load_data !== 32'h0 || pipe_stall !== 1'b0) begin
      n_errors++; $display("FAIL flush_drop: lv=%b ld=%h stall=%b required 0 0 0", load_valid, load_data, pipe_stall);
    end
    @(posedge clk); #1;
    dmem_rvalid = 0;
    do_access(0, 2'b11, 3'b010, 32'h0000_5004, 0, 32'h1234_5678, 0, 0, s);
    n_checks++;
    if (s !== 1) begin n_errors++; $display("FAIL after_flush_stall: %0d required 1", s); end
  endtask

  task automatic test_flush_req();
    mem_valid = 1; mem_write = 1; mem_store_type = 2'b10; mem_addr = 32'h0000_5100; mem_wdata = 32'h1;
    @(posedge clk); #1;
    idle_inputs();
    flush = 1;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL flush_req_before: req=%b required 1", dmem_req); end
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b0 || pipe_stall !== 1'b0) begin
      n_errors++; $display("FAIL flush_req_withdraw: req=%b stall=%b required 0 0", dmem_req, pipe_stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    mem_valid = 1; wb_load = 1; mem_load_type = 3'b010; mem_addr = 32'h0000_6000;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL mid_req_up: req=%b required 1", dmem_req); end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || pipe_stall !== 1'b0 || dmem_addr !== 32'h0 || bus_err !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset_async: req=%b stall=%b addr=%h berr=%b required 0 0 0 0",
                           dmem_req, pipe_stall, dmem_addr, bus_err);
    end
    @(posedge clk); #1;
    rst_n = 1;
    dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if (load_valid !== 1'b0 || pipe_stall !== 1'b0 || bus_err !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset_rvalid: lv=%b stall=%b berr=%b required 0 0 0", load_valid, pipe_stall, bus_err);
    end
    @(posedge clk); #1;
    dmem_rvalid = 0;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL mid_reset_idle: req=%b required 0", dmem_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s;
    do_access(1, 2'b00, 3'b111, 32'h0000_7000, 32'h0000_0011, 0, 0, 0, s);
    do_access(0, 2'b11, 3'b001, 32'h0000_7002, 0, 32'hFFFE_0000, 0, 0, s);
    do_access(1, 2'b01, 3'b111, 32'h0000_7006, 32'h0000_7788, 0, 0, 0, s);
    n_checks++;
    if (s !== 1) begin n_errors++; $display("FAIL b2b_stall_cycles: %0d required 1", s); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misalign(0, 2'b11, 3'b010, 32'h0000_3002, "lw_misalign");
    test_misalign(1, 2'b01, 3'b111, 32'h0000_3001, "sh_misalign");
    test_watchdog();
    test_flush_wait();
    test_flush_req();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (bus_q.size() != 0 || load_q.size() != 0) begin
      n_errors++; $display("FAIL scoreboard_drain: bus=%0d load=%0d required 0 0", bus_q.size(), load_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports `clk` and `rst_n`.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 mem_valid  in  1  the MEM-stage instruction is valid this cycle.
REQ-005 mem_write  in  1  the instruction is a store.
REQ-006 wb_load  in  1  the instruction is a load.
REQ-007 mem_store_type  in  2  SB=00, SH=01, SW=10, DEF=11.
REQ-008 mem_load_type  in  3  LB=000, LH=001, LW=010, LBU=011, LHU=100, DEF=111.
REQ-009 mem_addr  in  32  byte address.
REQ-010 mem_wdata  in  32  store data, right-aligned.
REQ-011 flush  in  1  pipeline flush.
REQ-012 dmem_req, dmem_we  out  1  bus request and write enable.
REQ-013 dmem_addr  out  32  word address {mem_addr[31:2], 2'b00}.
REQ-014 dmem_wstrb, dmem_wdata  out  4, 32  byte strobes and lane-shifted write data.
REQ-015 dmem_ready, dmem_rvalid  in  1  request accepted; read data valid.
REQ-016 dmem_rdata  in  32  read word.
REQ-017 pipe_stall  out  1  hold the IF/ID/EX/MEM registers.
REQ-018 load_valid, load_data  out  1, 32  extended load result.
REQ-019 misalign_err, bus_err  out  1  one-cycle exception pulses.

Function
REQ-020 FSM states SHALL be IDLE, REQ and WAIT.
REQ-021 An access SHALL be a store when mem_write=1 and mem_store_type!=DEF; otherwise a load when wb_load=1 and mem_load_type!=DEF; otherwise none. A store wins if both mem_write and wb_load are set.
REQ-022 In IDLE, with mem_valid=1, flush=0 and a misaligned access, the block SHALL pulse misalign_err for 1 cycle, stay in IDLE and issue no request.
  - Misaligned means: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0.
REQ-023 In IDLE, with mem_valid=1, flush=0 and an aligned access, the block SHALL latch type, addr[1:0] and data, and enter REQ on the next edge.
REQ-024 In REQ, dmem_req SHALL be 1, and dmem_we/addr/wstrb/wdata SHALL be driven from the latched values and held stable until dmem_ready=1.
REQ-025 Write strobes SHALL be:
  - SB: 4'b0001 << addr[1:0], with wdata byte replicated to all lanes.
  - SH: 4'b0011 << addr[1:0], with wdata halfword replicated to both halves.
  - SW: 4'b1111.
  - Loads: 4'b0000.
REQ-026 REQ with dmem_ready=1 SHALL go to IDLE for a store and to WAIT for a load.
REQ-027 In WAIT, on dmem_rvalid=1, load_valid SHALL be 1 that same cycle (combinational), and the FSM SHALL go to IDLE.
REQ-028 load_data SHALL select the addressed byte or halfword of dmem_rdata:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: the full word.
  - When load_valid=0: 0.
REQ-029 pipe_stall SHALL be asserted in each of these cases:
  - IDLE, with mem_valid, an aligned access and flush=0;
  - REQ, with dmem_ready=0;
  - WAIT, with dmem_rvalid=0.
  - It SHALL be 0 otherwise.
REQ-030 An 8-bit watchdog SHALL operate as follows:
  - Clear on entering REQ or WAIT, and count every cycle spent in REQ or WAIT.
  - On reaching 255 without completion, pulse bus_err, drop dmem_req and return to IDLE.
REQ-031 flush in IDLE SHALL suppress acceptance.
REQ-032 flush in REQ with dmem_ready=0 SHALL withdraw the request and go to IDLE the next cycle.
REQ-033 flush in REQ with dmem_ready=1 SHALL complete the handshake normally.
REQ-034 flush in WAIT SHALL set a drop flag: the response is still consumed, but load_valid stays 0.
REQ-035 mem_valid arriving while the FSM is not IDLE SHALL be ignored. The pipeline is stalled, so it is re-presented.
REQ-036 A back-to-back access SHALL be accepted in the IDLE cycle immediately following completion.

Reset
REQ-037 While rst_n=0 (asynchronously), the block SHALL be held as follows:
  - The FSM is in IDLE, and the watchdog and drop flag are 0.
  - dmem_req, dmem_we, dmem_wstrb, dmem_addr and dmem_wdata are 0.
  - pipe_stall, load_valid, load_data, misalign_err and bus_err are 0.
REQ-038 Reset asserted mid-access SHALL abandon the access with no error pulse; any later dmem_rvalid while in IDLE SHALL be ignored.

Verification
REQ-039 SB, addr 0x1003, wdata 0x000000AB, dmem_ready=1 after 2 cycles -> dmem_addr 0x1000, wstrb 4'b1000, wdata 0xABABABAB, stall for 3 cycles.
REQ-040 LB, addr 0x2001, rdata 0x00008000 -> load_data 0xFFFFFF80; LBU at the same address -> 0x00000080; load_valid for 1 cycle.
REQ-041 LW at 0x3002 and SH at 0x3001 -> misalign_err for 1 cycle each, no dmem_req, no stall.
REQ-042 LW with dmem_ready=1 but dmem_rvalid never asserted -> bus_err after 255 WAIT cycles, then IDLE, stall cleared.
REQ-043 flush during WAIT, then rvalid with 0x12345678 -> load_valid stays 0, FSM returns to IDLE.
REQ-044 rst_n low during REQ -> dmem_req=0 immediately; later rvalid yields no load_valid.
